// File: rtl/packed_int4_acc_unpack_pkg.sv
// packed_int4_acc_unpack_pkg: shared widths, FSM states and result-width helper for the dual-lane int4 datapath
package packed_int4_acc_unpack_pkg;
    localparam int PACK_W  = 45;
    localparam int LANE_SH = 22;
    localparam int ACC_W   = 48;

    typedef enum logic [1:0] {ST_ACC, ST_UNPACK, ST_OUT} state_t;

    // int4*int4 spans -56..64 (8 bits signed); each doubling of the window adds one bit
    function automatic int res_w(input int acc_len);
        return 8 + $clog2(acc_len);
    endfunction
endpackage

// File: rtl/packed_int4_acc_unpack_if.sv
// packed_int4_acc_unpack_if: packed-product input stream and result-pair output stream
interface packed_int4_acc_unpack_if
    import packed_int4_acc_unpack_pkg::*;
#(
    parameter int OUT_W = 12
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [PACK_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_hi;
    logic signed [OUT_W-1:0] out_lo;
    logic                    out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_hi, out_lo, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_hi, out_lo, out_sat
    );
endinterface

// File: rtl/packed_int4_acc_unpack_lane_sat_reduce.sv
// lane_sat_reduce: signed width reduction; clamps and flags when PACK_ACC_SAT_EN is defined, wraps otherwise
module lane_sat_reduce #(
    parameter int IN_W  = 22,
    parameter int OUT_W = 12
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);
`ifdef PACK_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic ovf;

    // value fits only when every bit from the output sign bit upward agrees
    assign ovf = !((&din[IN_W-1:OUT_W-1]) || !(|din[IN_W-1:OUT_W-1]));

    // clamp toward the bound on the side of the input sign, else keep the low bits
    always_comb begin
        sat  = SAT_EN && ovf;
        dout = sat ? {din[IN_W-1], {(OUT_W-1){~din[IN_W-1]}}} : din[OUT_W-1:0];
    end
endmodule

// File: rtl/packed_int4_acc_unpack.sv
// packed_int4_acc_unpack: accumulates ACC_LEN packed int4 products, splits lanes with borrow fix (optional clamp: PACK_ACC_SAT_EN)
module packed_int4_acc_unpack
    import packed_int4_acc_unpack_pkg::*;
#(
    parameter int ACC_LEN = 9,
    parameter int OUT_W   = res_w(ACC_LEN)
) (
    input  logic                          clk,
    input  logic                          rst,
    packed_int4_acc_unpack_if.slave       bus
);
    localparam int CNT_W = $clog2(ACC_LEN + 1);
    localparam int HI_W  = ACC_W - LANE_SH + 1;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] hi_q, hi_d, lo_q, lo_d, red_hi, red_lo;
    logic                    sat_q, sat_d, sat_hi, sat_lo;
    logic                    beat, last, unpack;
    logic signed [HI_W-1:0]  hi_lane;
    logic signed [LANE_SH-1:0] lo_lane;

    assign beat    = bus.in_valid && (state_q == ST_ACC);
    assign last    = beat && (cnt_q == CNT_W'(ACC_LEN - 1));
    assign unpack  = (state_q == ST_UNPACK);
    assign lo_lane = acc_q[LANE_SH-1:0];
    // a negative lower lane borrowed one from the upper lane; give it back
    assign hi_lane = {acc_q[ACC_W-1], acc_q[ACC_W-1:LANE_SH]} + {{(HI_W-1){1'b0}}, acc_q[LANE_SH-1]};

    lane_sat_reduce #(.IN_W(HI_W), .OUT_W(OUT_W)) u_red_hi (
        .din  (hi_lane),
        .dout (red_hi),
        .sat  (sat_hi)
    );

    lane_sat_reduce #(.IN_W(LANE_SH), .OUT_W(OUT_W)) u_red_lo (
        .din  (lo_lane),
        .dout (red_lo),
        .sat  (sat_lo)
    );

    // FSM state register; reset aborts any window or pending pair at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_ACC;
        else     state_q <= state_d;
    end

    // next state: accumulate, one unpack cycle, then hold until the pair is taken
    always_comb begin
        state_d = (state_q == ST_ACC)    ? (last ? ST_UNPACK : ST_ACC) :
                  (state_q == ST_UNPACK) ? ST_OUT :
                  (state_q == ST_OUT && !bus.out_ready) ? ST_OUT : ST_ACC;
    end

    // handshake outputs decoded from state; result lanes come straight from registers
    always_comb begin
        bus.in_ready  = (state_q == ST_ACC);
        bus.out_valid = (state_q == ST_OUT);
        bus.out_hi    = hi_q;
        bus.out_lo    = lo_q;
        bus.out_sat   = sat_q;
    end

    // datapath next values: beat counting, packed accumulation, result capture
    always_comb begin
        cnt_d = beat ? (last ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
        acc_d = unpack ? '0 : beat ? acc_q + {{(ACC_W-PACK_W){bus.in_data[PACK_W-1]}}, bus.in_data} : acc_q;
        hi_d  = unpack ? red_hi : hi_q;
        lo_d  = unpack ? red_lo : lo_q;
        sat_d = unpack ? (sat_hi || sat_lo) : sat_q;
    end

    // datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            sat_q <= sat_d;
        end
    end
endmodule

// File: tb/tb_packed_int4_acc_unpack.sv
// tb_packed_int4_acc_unpack: random and directed windows against a dot-product reference model, OUT_W=12 and OUT_W=9 in lockstep
module tb_packed_int4_acc_unpack;
    localparam int N = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   wa[N], wb[N], wc[N];
    bit   pend = 1'b0;
    int   pa, pb, pc;

    always #5 clk = ~clk;

    packed_int4_acc_unpack_if #(.OUT_W(12)) bus ();
    packed_int4_acc_unpack_if #(.OUT_W(9))  bus9 ();

    assign bus9.in_valid  = bus.in_valid;
    assign bus9.in_data   = bus.in_data;
    assign bus9.out_ready = bus.out_ready;

    packed_int4_acc_unpack #(.ACC_LEN(N), .OUT_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    packed_int4_acc_unpack #(.ACC_LEN(N), .OUT_W(9)) dut9 (
        .clk (clk),
        .rst (rst),
        .bus (bus9)
    );

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [44:0] pk(input int a, input int b, input int c);
        longint p;
        p = (longint'(a * c) <<< 22) + longint'(b * c);
        return p[44:0];
    endfunction

    function automatic int red(input int v, input int w, output int s);
        int lim;
        int r;
        lim = 1 << (w - 1);
        s = 0;
`ifdef PACK_ACC_SAT_EN
        r = v;
        if (v > lim - 1) begin s = 1; r = lim - 1; end
        if (v < -lim)    begin s = 1; r = -lim;    end
`else
        r = v & ((1 << w) - 1);
        if (r >= lim) r = r - (1 << w);
`endif
        return r;
    endfunction

    function automatic int rnd4();
        return int'($urandom_range(0, 15)) - 8;
    endfunction

    task automatic push(input int a, input int b, input int c);
        int n = 0;
        bus.in_data  = pk(a, b, c);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("in_ready_wait", n, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic fill(input int a, input int b, input int c);
        for (int i = 0; i < N; i++) begin
            wa[i] = a; wb[i] = b; wc[i] = c;
        end
    endtask

    task automatic fill_rnd();
        for (int i = 0; i < N; i++) begin
            wa[i] = rnd4(); wb[i] = rnd4(); wc[i] = rnd4();
        end
    endtask

    task automatic run_window(input string tag, input bit bp, input bit gaps);
        int eh = 0, el = 0, sh, sl;
        int h12, l12, s12, h9, l9, s9;
        if (pend) begin
            wa[0] = pa; wb[0] = pb; wc[0] = pc;
        end
        for (int i = 0; i < N; i++) begin
            eh += wa[i] * wc[i];
            el += wb[i] * wc[i];
        end
        h12 = red(eh, 12, sh); l12 = red(el, 12, sl); s12 = sh | sl;
        h9  = red(eh, 9, sh);  l9  = red(el, 9, sl);  s9  = sh | sl;
        for (int i = 0; i < N; i++) begin
            if (gaps && !(i == 0 && pend)) repeat ($urandom_range(0, 2)) @(negedge clk);
            push(wa[i], wb[i], wc[i]);
        end
        pend = 1'b0;
        chk({tag, "_unpack_valid"}, int'(bus.out_valid), 0);
        @(negedge clk);
        chk({tag, "_valid"}, int'(bus.out_valid), 1);
        chk({tag, "_hi"}, int'(bus.out_hi), h12);
        chk({tag, "_lo"}, int'(bus.out_lo), l12);
        chk({tag, "_sat"}, int'(bus.out_sat), s12);
        chk({tag, "_hi9"}, int'(bus9.out_hi), h9);
        chk({tag, "_lo9"}, int'(bus9.out_lo), l9);
        chk({tag, "_sat9"}, int'(bus9.out_sat), s9);
        if (bp) begin
            bus.out_ready = 1'b0;
            pa = rnd4(); pb = rnd4(); pc = rnd4();
            bus.in_data  = pk(pa, pb, pc);
            bus.in_valid = 1'b1;
            pend = 1'b1;
            repeat (5) begin
                @(negedge clk);
                chk({tag, "_bp_valid"}, int'(bus.out_valid), 1);
                chk({tag, "_bp_in_ready"}, int'(bus.in_ready), 0);
                chk({tag, "_bp_hi"}, int'(bus.out_hi), h12);
                chk({tag, "_bp_lo"}, int'(bus.out_lo), l12);
                chk({tag, "_bp_sat"}, int'(bus.out_sat), s12);
            end
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_done_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_done_in_ready"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_hi", int'(bus.out_hi), 0);
        chk("rst_out_lo", int'(bus.out_lo), 0);
        chk("rst_out_sat", int'(bus.out_sat), 0);
        rst = 1'b0;
        @(negedge clk);

        fill(3, -2, 5);   run_window("nominal", 1'b0, 1'b0);
        fill(1, -1, 1);   run_window("borrow", 1'b0, 1'b0);
        fill(-8, -8, -8); run_window("ext_neg", 1'b0, 1'b0);
        fill(-8, 7, -8);  run_window("ext_mix", 1'b0, 1'b0);
        fill(7, -8, 7);   run_window("ext_pos", 1'b0, 1'b1);

        fill_rnd();       run_window("bp", 1'b1, 1'b0);
        fill_rnd();       run_window("after_bp", 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) push(1, 1, 1);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        fill(2, -3, 1);   run_window("rst_mid", 1'b0, 1'b0);

        fill_rnd();
        for (int i = 0; i < N; i++) push(wa[i], wb[i], wc[i]);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("rst_out_pending", int'(bus.out_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid_async", int'(bus.out_valid), 0);
        chk("rst_out_hi_async", int'(bus.out_hi), 0);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out_in_ready", int'(bus.in_ready), 1);
        fill_rnd();       run_window("after_rst_out", 1'b0, 1'b1);

        for (int k = 0; k < 24; k++) begin
            fill_rnd();
            run_window("rand", ($urandom_range(0, 3) == 0), 1'b1);
        end
        if (pend) begin
            fill_rnd();
            run_window("tail", 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
